writeback_scoreboard: RTL

//  Write-back stage and register-busy scoreboard for the 5-stage MIPS pipeline.

---
 rtl/writeback_scoreboard_if.sv | 38 +++
 rtl/writeback_scoreboard.sv | 101 ++++++++++
 2 files changed

// File: rtl/writeback_scoreboard_if.sv
// Write-back / scoreboard bus: MEM/WB result, decoder issue request, and
// register-file write plus scoreboard status back toward the pipeline.
interface writeback_scoreboard_if #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
);
  logic          wb_valid;
  logic          wb_reg_write;
  logic          wb_mem_to_reg;
  logic [AW-1:0] wb_rd;
  logic [DW-1:0] alu_data_out;
  logic [DW-1:0] mem_data_out;
  logic          issue_valid;
  logic          issue_reg_write;
  logic [AW-1:0] issue_rd;
  logic [AW-1:0] src_rs;
  logic [AW-1:0] src_rt;
  logic [DW-1:0] reg_wr_data;
  logic [AW-1:0] reg_wr_addr;
  logic          reg_write;
  logic          stall;
  logic [NREG-1:0] busy_flags;
  logic [AW:0]   pending_count;
  logic          wb_orphan;

  modport master (
    output wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd, alu_data_out, mem_data_out,
    output issue_valid, issue_reg_write, issue_rd, src_rs, src_rt,
    input  reg_wr_data, reg_wr_addr, reg_write, stall, busy_flags, pending_count, wb_orphan
  );

  modport slave (
    input  wb_valid, wb_reg_write, wb_mem_to_reg, wb_rd, alu_data_out, mem_data_out,
    input  issue_valid, issue_reg_write, issue_rd, src_rs, src_rt,
    output reg_wr_data, reg_wr_addr, reg_write, stall, busy_flags, pending_count, wb_orphan
  );
endinterface

// File: rtl/writeback_scoreboard.sv
// MIPS write-back stage: registers the register-file write and owns the
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module writeback_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  writeback_scoreboard_if.slave  bus
);

  localparam logic [AW:0] CNT_MAX = (AW+1)'(NREG - 1);

  logic [DW-1:0]   reg_wr_data_q, reg_wr_data_d;
  logic [AW-1:0]   reg_wr_addr_q, reg_wr_addr_d;
  logic            reg_write_q,   reg_write_d;
  logic [NREG-1:0] busy_q,        busy_d;
  logic [AW:0]     count_q,       count_d;
  logic            orphan_q,      orphan_d;

  logic            wb_fire;
  logic            set_fire;
  logic            stall_c;
  logic            inc;
  logic            dec;
  logic [NREG-1:0] busy_rd;

  always_comb begin
    wb_fire = bus.wb_valid & bus.wb_reg_write & (bus.wb_rd != '0);

    // r0 is hardwired: read its flag as clear regardless of state
    busy_rd    = busy_q;
    busy_rd[0] = 1'b0;

    // No bypass of a same-edge clear: the hazard is resolved one cycle late
    stall_c = bus.issue_valid &
              (busy_rd[bus.src_rs] | busy_rd[bus.src_rt] |
               (bus.issue_reg_write & busy_rd[bus.issue_rd]));

    set_fire = bus.issue_valid & ~stall_c & bus.issue_reg_write &
               (bus.issue_rd != '0);
  end

  always_comb begin
    reg_write_d   = wb_fire;
    reg_wr_addr_d = reg_wr_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    if (wb_fire) begin
      reg_wr_addr_d = bus.wb_rd;
      reg_wr_data_d = bus.wb_mem_to_reg ? bus.mem_data_out : bus.alu_data_out;
    end
  end

  always_comb begin
    busy_d   = busy_q;
    orphan_d = orphan_q;
    count_d  = count_q;

    // Clear applied before set so a same-register collision leaves the flag set
    if (wb_fire) begin
      busy_d[bus.wb_rd] = 1'b0;
      if (!busy_q[bus.wb_rd]) orphan_d = 1'b1;
    end
    if (set_fire) busy_d[bus.issue_rd] = 1'b1;

    inc = set_fire & ~busy_q[bus.issue_rd] & (count_q != CNT_MAX);
    dec = wb_fire & busy_q[bus.wb_rd] &
          ~(set_fire & (bus.issue_rd == bus.wb_rd)) & (count_q != '0);

    if (inc && !dec)      count_d = count_q + 1'b1;
    else if (dec && !inc) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reg_wr_data_q <= '0;
      reg_wr_addr_q <= '0;
      reg_write_q   <= 1'b0;
      busy_q        <= '0;
      count_q       <= '0;
      orphan_q      <= 1'b0;
    end else begin
      reg_wr_data_q <= reg_wr_data_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      reg_write_q   <= reg_write_d;
      busy_q        <= busy_d;
      count_q       <= count_d;
      orphan_q      <= orphan_d;
    end
  end

  assign bus.reg_wr_data   = reg_wr_data_q;
  assign bus.reg_wr_addr   = reg_wr_addr_q;
  assign bus.reg_write     = reg_write_q;
  assign bus.stall         = stall_c;
  assign bus.busy_flags    = busy_q;
  assign bus.pending_count = count_q;
  assign bus.wb_orphan     = orphan_q;

endmodule
